// File: rtl/trace_filter_multi.sv
// Trace filter between the core trace tap and the trace FIFO: keeps instructions that hit an
// enabled event class plus a programmable trail after each event, with saturating statistics.
module trace_filter_multi #(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned MAX_TRAIL   = 8,
    parameter int unsigned TRAIL_W     = $clog2(MAX_TRAIL + 1),
    parameter int unsigned CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pc_valid,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [3:0]             cfg_class_en,
    input  logic [TRAIL_W-1:0]     cfg_trail_len,
    input  logic [INSTR_WIDTH-1:0] cfg_match_mask,
    input  logic [INSTR_WIDTH-1:0] cfg_match_value,
    input  logic                   cfg_bypass,
    input  logic                   cnt_clear,
    output logic                   drop_instr,
    output logic                   event_hit,
    output logic                   trailing,
    output logic [CNT_W-1:0]       kept_count,
    output logic [CNT_W-1:0]       dropped_count
);

    localparam logic [6:0]  BRANCH_OPCODE   = 7'b1100011;
    localparam logic [6:0]  JAL_OPCODE      = 7'b1101111;
    localparam logic [6:0]  JALR_OPCODE     = 7'b1100111;
    localparam logic [31:0] WFI_INSTRUCTION = 32'h1050_0073;
    localparam logic [1:0]  C_Q1_OP         = 2'b01;
    localparam logic [1:0]  C_Q2_OP         = 2'b10;
    localparam logic [1:0]  C_BRANCH_F3_MSB = 2'b11;
    localparam logic [2:0]  C_JAL_F3        = 3'b001;
    localparam logic [3:0]  C_JALR_F4       = 4'b1001;
    localparam logic [TRAIL_W-1:0] TRAIL_MAX = TRAIL_W'(MAX_TRAIL);

    typedef enum logic {IDLE, TRAILING} trail_state_t;

    trail_state_t       state;
    logic [TRAIL_W-1:0] trail_cnt;
    logic [TRAIL_W-1:0] trail_nxt;
    logic [TRAIL_W-1:0] load_len;
    logic [31:0]        iw;
    logic [3:0]         cls;
    logic               keep;

    assign iw = instr[31:0];

    // Event class decode; compressed forms only exist when iw[1:0] != 2'b11.
    always_comb begin
        cls    = '0;
        cls[0] = (iw[6:0] == BRANCH_OPCODE)
               | ((iw[1:0] == C_Q1_OP) & (iw[15:14] == C_BRANCH_F3_MSB));
        cls[1] = (iw[6:0] == JAL_OPCODE) | (iw[6:0] == JALR_OPCODE)
               | ((iw[1:0] == C_Q1_OP) & (iw[15:13] == C_JAL_F3))
               | ((iw[1:0] == C_Q2_OP) & (iw[15:12] == C_JALR_F4)
                  & (iw[11:7] != 5'd0) & (iw[6:2] == 5'd0));
        cls[2] = (iw == WFI_INSTRUCTION);
        cls[3] = ((instr & cfg_match_mask) == cfg_match_value);
    end

    assign event_hit  = pc_valid & (|(cls & cfg_class_en));
    assign keep       = pc_valid & (cfg_bypass | event_hit | (trail_cnt != '0));
    assign drop_instr = ~keep;
    assign load_len   = (cfg_trail_len > TRAIL_MAX) ? TRAIL_MAX : cfg_trail_len;

    // Next trail count: an event reloads (no accumulation), otherwise count down per valid instr.
    always_comb begin
        trail_nxt = trail_cnt;
        if (pc_valid) begin
            if (event_hit) begin
                trail_nxt = load_len;
            end else if (trail_cnt != '0) begin
                trail_nxt = trail_cnt - TRAIL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trail_cnt <= '0;
            state     <= IDLE;
        end else begin
            trail_cnt <= trail_nxt;
            state     <= (trail_nxt != '0) ? TRAILING : IDLE;
        end
    end

    assign trailing = (state == TRAILING);

    // Saturating statistics; clear wins over the increment of the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kept_count    <= '0;
            dropped_count <= '0;
        end else if (cnt_clear) begin
            kept_count    <= '0;
            dropped_count <= '0;
        end else if (pc_valid) begin
            if (keep) begin
                if (kept_count != '1) kept_count <= kept_count + CNT_W'(1);
            end else begin
                if (dropped_count != '1) dropped_count <= dropped_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/trace_filter_multi.md
Name: trace_filter_multi

Overview:
Parametrised successor to the single-trail trace filter in the continuous monitoring system. It sits between the core trace tap and the trace FIFO. Per valid instruction it decides keep/drop from four runtime-enabled event classes: branch, jump, WFI, and a mask/value custom match. After an event it keeps a programmable run of following instructions, with optional bypass, and it provides saturating kept/dropped statistics counters.

Parameters:
INSTR_WIDTH, 32, instruction bus width; must be >= 32; event decode uses bits [31:0] and the package opcode constants.
MAX_TRAIL, 8, maximum number of post-event instructions kept; must be >= 1.
TRAIL_W, $clog2(MAX_TRAIL+1), width of the trail length and trail counter.
CNT_W, 32, width of the kept/dropped statistics counters.

Ports:
clk  in  1  single clock; all state on rising edge.
rst  in  1  asynchronous, active-high reset.
pc_valid  in  1  instr is a retired instruction this cycle.
instr  in  INSTR_WIDTH  instruction word; compressed forms occupy [15:0].
cfg_class_en  in  4  class enables: [0] branch, [1] jump, [2] WFI, [3] custom match.
cfg_trail_len  in  TRAIL_W  number of valid instructions kept after an event (0 = none).
cfg_match_mask  in  INSTR_WIDTH  custom class mask.
cfg_match_value  in  INSTR_WIDTH  custom class value.
cfg_bypass  in  1  keep every valid instruction.
cnt_clear  in  1  synchronous clear of both statistics counters.
drop_instr  out  1  combinational; 1 = discard current instr.
event_hit  out  1  combinational; current valid instr matches an enabled class.
trailing  out  1  registered; trail counter non-zero.
kept_count  out  CNT_W  saturating count of kept valid instructions.
dropped_count  out  CNT_W  saturating count of dropped valid instructions.

Behaviour:
- Class decode (combinational):
  - branch = BRANCH_OPCODE, or C_BRANCH_OPCODE with funct3 MSBs.
  - jump = JAL/JALR, or C_JAL/C_JALR per package constants.
  - WFI = instr[31:0] == WFI_INSTRUCTION.
  - custom = (instr & cfg_match_mask) == cfg_match_value.
  - event_hit = pc_valid & OR(class & cfg_class_en).
- keep = pc_valid & (cfg_bypass | event_hit | trail_cnt != 0).
- drop_instr = ~keep. drop_instr = 1 whenever pc_valid = 0.
- Trail counter trail_cnt[TRAIL_W-1:0], states IDLE (cnt = 0) and TRAILING (cnt > 0). On each rising edge with pc_valid = 1, in priority order:
  - event_hit: load min(cfg_trail_len, MAX_TRAIL). This reloads even if already trailing; no accumulation.
  - otherwise, cnt > 0: decrement by 1.
  - otherwise: hold 0.
- pc_valid = 0: counter holds. Gaps between valid instructions do not consume the trail.
- Latency: the kept trail is the cfg_trail_len valid instructions immediately after the event instruction, with no skipped instruction.
- cfg_trail_len is sampled only at event load. Changes mid-trail do not alter the remaining count.
- cfg_bypass does not affect the trail counter, which keeps running underneath. Deasserting bypass mid-trail resumes normal filtering with the current count.
- All classes disabled and bypass = 0: only an in-progress trail is kept, then everything is dropped.
- trailing = (trail_cnt != 0), registered.
- Counters, on pc_valid:
  - kept_count increments when keep = 1; dropped_count increments when keep = 0.
  - Both saturate at all-ones and never wrap.
  - cnt_clear = 1 forces both to 0 and takes priority over an increment in the same cycle; that cycle's instruction is not counted.
- Reset (async assert, sync deassert at source): trail_cnt = 0, trailing = 0, kept_count = 0, dropped_count = 0.
  - Outputs derived combinationally follow inputs with trail_cnt = 0.
  - Reset mid-trail abandons the trail immediately.

Test Plan:
- Trail of 2: rst released; cfg_class_en = 4'b0001, cfg_trail_len = 2; feed valid 0x00000063 (BEQ), 0x00000013, 0x00000013, 0x00000013 -> drop_instr = 0, 0, 0, 1. trailing high during the 2nd and 3rd instructions. kept_count = 3, dropped_count = 1.
- Reload and gaps: trail_len = 3, class_en = 4'b0011; valid BEQ, two idle cycles, 0x00000013, 0x0000006F (JAL), then 4 NOPs -> NOP after the gap kept; JAL reloads to 3; next 3 NOPs kept, 4th dropped.
- Clamp, WFI and mid-trail reset: MAX_TRAIL = 8, cfg_trail_len = 15, class_en = 4'b0100; valid 0x10500073 (WFI) then 10 NOPs -> exactly 8 NOPs kept.
  - Repeat, asserting rst after 3 NOPs -> trailing = 0 immediately; next NOP dropped; counters 0.
- Custom match and bypass: mask = 0x0000707F, value = 0x00002003 (LW), class_en = 4'b1000, trail_len = 0; feed 0x0000A083 (LW) and 0x00000013 -> kept, dropped.
  - Set cfg_bypass = 1 -> NOP kept; event_hit = 0.
- Counter saturation and clear: CNT_W = 4; 20 dropped valid instrs -> dropped_count = 15 and holds.
  - Pulse cnt_clear together with a valid instr -> both counters 0, that instr not counted.
